// File: rtl/light_pkg.sv
// Shared types and constants for the light-push column controller.
// Holds the round/match state encoding, the winner codes driven on the
// winner output, and a helper that sizes the post-round display counter.
package light_pkg;

  // Round/match sequencing states.
  //   INIT : column reset strobe is high for one cycle
  //   PLAY : presses are accepted and turned into moves or a round win
  //   HOLD : winner is displayed for a fixed number of cycles
  //   OVER : match finished, everything frozen until Reset
  typedef enum logic [1:0] {
    INIT = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2,
    OVER = 2'd3
  } state_t;

  // Encoding of the winner output.
  localparam logic [1:0] WIN_NONE   = 2'd0;
  localparam logic [1:0] WIN_UP     = 2'd1;
  localparam logic [1:0] WIN_BOTTOM = 2'd2;

  // Width of a counter that must be able to hold 0..hold_cycles.
  function automatic int hold_cnt_width(input int hold_cycles);
    return $clog2(hold_cycles + 1);
  endfunction

endpackage

// File: rtl/light_column_ctrl_btn_sync_edge.sv
// Button conditioner: synchronises one raw asynchronous button into the
// Clock domain and turns each rising edge into a single-cycle press.
// Latency: a raw level first sampled at edge n shows up as press during
// the cycle after edge n+SYNC_STAGES-1. No backpressure.
//
// Ports:
//   Clock  : system clock
//   Reset  : synchronous, active-high; clears the chain and edge history
//   raw    : asynchronous button level, active-high
//   press  : one-cycle strobe on each synchronised rising edge
module btn_sync_edge
  import light_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic raw,
  output logic press
);

  // sync[0] is the metastability-catching flop; sync[SYNC_STAGES-1] is the
  // first stage that is safe to use in logic.
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_prev;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync      <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], raw};
      sync_prev <= sync[SYNC_STAGES-1];
    end
  end

  // The history flop keeps updating regardless of what the consumer does
  // with press, so a held button never produces a second press.
  assign press = sync[SYNC_STAGES-1] & ~sync_prev;

endmodule

// File: rtl/light_column_ctrl.sv
// Round/match controller for the centre-light column of the light-push game.
// Latency: button edge sampled at edge n -> move pulse registered at edge
// n+SYNC_STAGES (high for one cycle). No backpressure; presses outside PLAY
// are dropped.
//
// Ports:
//   Clock, Reset  : system clock, synchronous active-high reset
//   btn_up        : raw up-player button
//   btn_bottom    : raw bottom-player button
//   lights_in     : lightOn vector from the cells, bit 0 = bottom end
//   up_pulse      : one-cycle move-up strobe to the cells
//   bottom_pulse  : one-cycle move-down strobe to the cells
//   cell_reset    : re-centres the column (high in reset and in INIT)
//   up_score      : rounds won by the up player
//   bottom_score  : rounds won by the bottom player
//   winner        : WIN_NONE / WIN_UP / WIN_BOTTOM, valid in HOLD and OVER
//   match_over    : high once a player reaches WIN_SCORE
module light_column_ctrl
  import light_pkg::*;
#(
  parameter int NUM_LIGHTS  = 9,
  parameter int SCORE_W     = 3,
  parameter int WIN_SCORE   = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  btn_up,
  input  logic                  btn_bottom,
  input  logic [NUM_LIGHTS-1:0] lights_in,
  output logic                  up_pulse,
  output logic                  bottom_pulse,
  output logic                  cell_reset,
  output logic [SCORE_W-1:0]    up_score,
  output logic [SCORE_W-1:0]    bottom_score,
  output logic [1:0]            winner,
  output logic                  match_over
);

  localparam int                 HOLD_W      = hold_cnt_width(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
  localparam logic [SCORE_W-1:0] WIN_SCORE_V = SCORE_W'(WIN_SCORE);

  state_t             state;
  logic [HOLD_W-1:0]  hold_cnt;

  logic               press_up;
  logic               press_bottom;
  logic               accept_up;
  logic               accept_bottom;
  logic               top_lit;
  logic               bottom_lit;
  logic [SCORE_W-1:0] winner_score;
  logic               unused_lights;

  // ---------------------------------------------------------------------
  // Button conditioning, one instance per player
  // ---------------------------------------------------------------------
  btn_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_up (
    .Clock(Clock),
    .Reset(Reset),
    .raw  (btn_up),
    .press(press_up)
  );

  btn_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_bottom (
    .Clock(Clock),
    .Reset(Reset),
    .raw  (btn_bottom),
    .press(press_bottom)
  );

  // ---------------------------------------------------------------------
  // Arbitration and end-of-column detection
  // ---------------------------------------------------------------------
  // Presses landing in the same cycle cancel each other: neither player
  // gets an advantage from a tie.
  assign accept_up     = press_up & ~press_bottom;
  assign accept_bottom = press_bottom & ~press_up;

  // Only the two end cells decide a round. The column is trusted to be
  // one-hot; a malformed vector is passed through without correction.
  assign top_lit    = lights_in[NUM_LIGHTS-1];
  assign bottom_lit = lights_in[0];

  // The interior cells are never inspected by the controller.
  assign unused_lights = ^lights_in;

  // Score of whoever won the round that is currently being displayed.
  assign winner_score = (winner == WIN_UP) ? up_score : bottom_score;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
  endfunction

  // ---------------------------------------------------------------------
  // Round / match sequencer. Every output is a flop written here so the
  // cells see glitch-free strobes.
  // ---------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= INIT;
      hold_cnt     <= '0;
      up_pulse     <= 1'b0;
      bottom_pulse <= 1'b0;
      cell_reset   <= 1'b1;
      up_score     <= '0;
      bottom_score <= '0;
      winner       <= WIN_NONE;
      match_over   <= 1'b0;
    end else begin
      // Move strobes are single-cycle by construction.
      up_pulse     <= 1'b0;
      bottom_pulse <= 1'b0;

      case (state)
        // cell_reset entered this state already high (from Reset or from
        // the end of HOLD), so leaving after one cycle gives a one-cycle
        // column reset.
        INIT: begin
          cell_reset <= 1'b0;
          state      <= PLAY;
        end

        // A push off the end wins the round instead of moving the light,
        // so no pulse is issued in that case.
        PLAY: begin
          if (accept_up) begin
            if (top_lit) begin
              up_score <= sat_inc(up_score);
              winner   <= WIN_UP;
              hold_cnt <= '0;
              state    <= HOLD;
            end else begin
              up_pulse <= 1'b1;
            end
          end else if (accept_bottom) begin
            if (bottom_lit) begin
              bottom_score <= sat_inc(bottom_score);
              winner       <= WIN_BOTTOM;
              hold_cnt     <= '0;
              state        <= HOLD;
            end else begin
              bottom_pulse <= 1'b1;
            end
          end
        end

        // The score compared here already includes the round just won.
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            if (winner_score == WIN_SCORE_V) begin
              match_over <= 1'b1;
              state      <= OVER;
            end else begin
              winner     <= WIN_NONE;
              cell_reset <= 1'b1;
              state      <= INIT;
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        // Sticky until Reset; all state is frozen.
        OVER: begin
        end

        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_light_column_ctrl.sv
module tb_light_column_ctrl;

  localparam int NL    = 9;
  localparam int SW    = 3;
  localparam int WINS  = 3;
  localparam int HOLDC = 4;
  localparam int SYNC  = 2;

  localparam logic [NL-1:0] LC = 9'b000010000;
  localparam logic [NL-1:0] LT = 9'b100000000;
  localparam logic [NL-1:0] LB = 9'b000000001;

  logic          Clock;
  logic          Reset;
  logic          btn_up;
  logic          btn_bottom;
  logic [NL-1:0] lights_in;
  logic          up_pulse;
  logic          bottom_pulse;
  logic          cell_reset;
  logic [SW-1:0] up_score;
  logic [SW-1:0] bottom_score;
  logic [1:0]    winner;
  logic          match_over;

  light_column_ctrl #(
    .NUM_LIGHTS (NL),
    .SCORE_W    (SW),
    .WIN_SCORE  (WINS),
    .HOLD_CYCLES(HOLDC),
    .SYNC_STAGES(SYNC)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .btn_up      (btn_up),
    .btn_bottom  (btn_bottom),
    .lights_in   (lights_in),
    .up_pulse    (up_pulse),
    .bottom_pulse(bottom_pulse),
    .cell_reset  (cell_reset),
    .up_score    (up_score),
    .bottom_score(bottom_score),
    .winner      (winner),
    .match_over  (match_over)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // {up_pulse, bottom_pulse, cell_reset, up_score, bottom_score, winner, match_over}
  logic [11:0] dut_out;
  assign dut_out = {up_pulse, bottom_pulse, cell_reset, up_score, bottom_score,
                    winner, match_over};

  int n_checks = 0;
  int n_pass   = 0;

  function automatic string fmt(input logic [11:0] v);
    return $sformatf("up_p=%b bot_p=%b cr=%b us=%0d bs=%0d win=%0d over=%b",
                     v[11], v[10], v[9], v[8:6], v[5:3], v[2:1], v[0]);
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got [%s] expected [%s] at %0t", name, fmt(act), fmt(exp), $time);
  endtask

  // ---------------------------------------------------------------------
  // Reference model: the game rules at event level. Button history is a
  // list of past samples; the display period is a countdown of remaining
  // cycles; scores are plain integers.
  // ---------------------------------------------------------------------
  localparam int P_INIT = 0, P_PLAY = 1, P_HOLD = 2, P_OVER = 3;
  bit hu[$];
  bit hb[$];
  int m_phase = P_INIT;
  int m_left  = 0;
  int m_us = 0, m_bs = 0, m_win = 0;
  bit m_upp = 0, m_bp = 0, m_cr = 1, m_over = 0;

  function automatic logic [11:0] model_vec();
    return {m_upp, m_bp, m_cr, 3'(m_us), 3'(m_bs), 2'(m_win), m_over};
  endfunction

  task automatic model_step(input bit r, input bit u, input bit b, input logic [NL-1:0] L);
    bit pu, pb;
    if (r) begin
      hu.delete();
      hb.delete();
      repeat (SYNC + 1) begin
        hu.push_back(1'b0);
        hb.push_back(1'b0);
      end
      m_phase = P_INIT; m_us = 0; m_bs = 0; m_win = 0;
      m_upp = 0; m_bp = 0; m_cr = 1; m_over = 0;
      return;
    end
    // hu[0] is the previous edge's sample; a press seen now is a rise that
    // happened SYNC samples ago.
    pu = hu[SYNC-1] && !hu[SYNC];
    pb = hb[SYNC-1] && !hb[SYNC];
    hu.push_front(u); void'(hu.pop_back());
    hb.push_front(b); void'(hb.pop_back());
    m_upp = 0;
    m_bp  = 0;
    case (m_phase)
      P_INIT: begin
        m_cr = 0;
        m_phase = P_PLAY;
      end
      P_PLAY: begin
        if (pu && !pb) begin
          if (L[NL-1]) begin
            m_us = (m_us < 7) ? m_us + 1 : 7;
            m_win = 1; m_left = HOLDC; m_phase = P_HOLD;
          end else m_upp = 1;
        end else if (pb && !pu) begin
          if (L[0]) begin
            m_bs = (m_bs < 7) ? m_bs + 1 : 7;
            m_win = 2; m_left = HOLDC; m_phase = P_HOLD;
          end else m_bp = 1;
        end
      end
      P_HOLD: begin
        m_left--;
        if (m_left == 0) begin
          if (((m_win == 1) ? m_us : m_bs) == WINS) begin
            m_over = 1;
            m_phase = P_OVER;
          end else begin
            m_win = 0; m_cr = 1; m_phase = P_INIT;
          end
        end
      end
      default: begin
      end
    endcase
  endtask

  // Drive one clock of stimulus: inputs change on the falling edge, the
  // model advances with the rising edge, outputs are sampled 1 unit later.
  task automatic cycle(input bit r, input bit u, input bit b, input logic [NL-1:0] L);
    @(negedge Clock);
    Reset = r; btn_up = u; btn_bottom = b; lights_in = L;
    @(posedge Clock);
    model_step(r, u, b, L);
    #1;
  endtask

  // ---------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------
  typedef struct {
    bit            rst;
    bit            bu;
    bit            bb;
    logic [NL-1:0] lights;
    logic [11:0]   exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, input bit u, input bit b, input logic [NL-1:0] L,
                     input bit up, input bit bp, input bit cr, input logic [2:0] us,
                     input logic [2:0] bs, input logic [1:0] w, input bit mo);
    vec_t v;
    v.rst = r; v.bu = u; v.bb = b; v.lights = L;
    v.exp = {up, bp, cr, us, bs, w, mo};
    tbl.push_back(v);
  endtask

  initial begin
    bit ru, rb, rr;
    int rst_left;
    int sel;
    logic [NL-1:0] rl;

    Reset = 1'b1; btn_up = 1'b0; btn_bottom = 1'b0; lights_in = LC;

    // Reset 3 cycles, then INIT -> PLAY.
    repeat (3) add(1, 0, 0, LC, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, LC, 0, 0, 0, 0, 0, 0, 0);
    // Up press held 10 cycles: one pulse, two edges after first sample.
    add(0, 1, 0, LC, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, LC, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, LC, 1, 0, 0, 0, 0, 0, 0);
    repeat (7) add(0, 1, 0, LC, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) add(0, 0, 0, LC, 0, 0, 0, 0, 0, 0, 0);
    // Simultaneous presses: tie, nothing happens.
    repeat (4) add(0, 1, 1, LC, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) add(0, 0, 0, LC, 0, 0, 0, 0, 0, 0, 0);
    // Solo bottom press.
    add(0, 0, 1, LC, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, LC, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, LC, 0, 1, 0, 0, 0, 0, 0);
    repeat (3) add(0, 0, 0, LC, 0, 0, 0, 0, 0, 0, 0);
    // Up pushes the light off the top: round win, 4-cycle display.
    add(0, 1, 0, LT, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, LT, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, LT, 0, 0, 0, 1, 0, 1, 0);
    repeat (3) add(0, 0, 0, LT, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, LT, 0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, LC, 0, 0, 0, 1, 0, 0, 0);
    // Bottom wins three rounds -> match over.
    for (int k = 1; k <= 3; k++) begin
      add(0, 0, 1, LB, 0, 0, 0, 1, 3'(k - 1), 0, 0);
      add(0, 0, 1, LB, 0, 0, 0, 1, 3'(k - 1), 0, 0);
      repeat (4) add(0, 0, 0, LB, 0, 0, 0, 1, 3'(k), 2, 0);
      if (k < 3) begin
        add(0, 0, 0, LB, 0, 0, 1, 1, 3'(k), 0, 0);
        add(0, 0, 0, LB, 0, 0, 0, 1, 3'(k), 0, 0);
      end else begin
        add(0, 0, 0, LB, 0, 0, 0, 1, 3, 2, 1);
      end
    end
    // Presses after the match are ignored.
    add(0, 1, 0, LT, 0, 0, 0, 1, 3, 2, 1);
    add(0, 1, 1, LB, 0, 0, 0, 1, 3, 2, 1);
    add(0, 0, 1, LB, 0, 0, 0, 1, 3, 2, 1);
    repeat (3) add(0, 0, 0, LC, 0, 0, 0, 1, 3, 2, 1);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].bu, tbl[i].bb, tbl[i].lights);
      chk($sformatf("vec%0d", i), dut_out, tbl[i].exp);
    end

    // Reset while the winner display counter is at 2.
    cycle(1, 0, 0, LC);
    cycle(1, 0, 0, LC);
    chk("hold_rst_pre", dut_out, 12'b001_000_000_00_0);
    cycle(0, 0, 0, LC);
    cycle(0, 1, 0, LT);
    cycle(0, 1, 0, LT);
    cycle(0, 0, 0, LT);
    chk("hold_rst_enter", dut_out, 12'b000_001_000_01_0);
    cycle(0, 0, 0, LT);
    cycle(0, 0, 0, LT);
    chk("hold_rst_cnt2", dut_out, 12'b000_001_000_01_0);
    cycle(1, 0, 0, LT);
    chk("hold_rst_apply", dut_out, 12'b001_000_000_00_0);
    cycle(0, 0, 0, LC);
    chk("hold_rst_init", dut_out, 12'b000_000_000_00_0);

    // Randomised play against the reference model.
    ru = 0; rb = 0; rst_left = 2;
    for (int c = 0; c < 4000; c++) begin
      if (rst_left == 0 && $urandom_range(0, 99) == 0) rst_left = $urandom_range(1, 3);
      rr = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      if ($urandom_range(0, 3) == 0) ru = ~ru;
      if ($urandom_range(0, 3) == 0) rb = ~rb;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    rl = LT;
        2, 3:    rl = LB;
        4:       rl = LT | LB;
        5:       rl = '0;
        default: rl = NL'(1) << $urandom_range(1, NL - 2);
      endcase
      cycle(rr, ru, rb, rl);
      chk("random", dut_out, model_vec());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/light_column_ctrl.md
Name: light_column_ctrl

Overview:
Round/match controller that sequences the column of center-light cells in the light-push game. It synchronises and edge-detects the two raw player buttons and arbitrates simultaneous presses. It issues single-cycle up/bottom move pulses to the cells, detects when the lit cell is pushed off either end, and keeps per-player scores. It also drives the cell column reset between rounds and freezes play when a match is won.

Parameters:
NUM_LIGHTS, 9, number of cells in the column; index 0 = bottom end, NUM_LIGHTS-1 = top end
SCORE_W, 3, score counter width
WIN_SCORE, 3, round wins needed to win the match (1..2^SCORE_W-1)
HOLD_CYCLES, 4, length of the post-round winner display, in cycles (>=1)
SYNC_STAGES, 2, button synchroniser depth (>=2)

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high reset
btn_up  in  1  raw asynchronous player-up button, active-high
btn_bottom  in  1  raw asynchronous player-bottom button, active-high
lights_in  in  NUM_LIGHTS  lightOn vector from the cells
up_pulse  out  1  one-cycle move-up strobe to the cells
bottom_pulse  out  1  one-cycle move-down strobe to the cells
cell_reset  out  1  reset to every cell; the column returns to center-lit
up_score  out  SCORE_W  rounds won by the up player
bottom_score  out  SCORE_W  rounds won by the bottom player
winner  out  2  0 = none, 1 = up, 2 = bottom; meaningful in HOLD and OVER
match_over  out  1  high while the match is finished

Behaviour:
- Interface: reset Reset, synchronous, active-high; clock Clock. All outputs are registered.
- Reset values: up_pulse=0, bottom_pulse=0, cell_reset=1, scores=0, winner=0, match_over=0, state=INIT. Synchroniser flops and edge-detect history clear to 0.
- Input path: each button passes through a SYNC_STAGES flop chain, then rising-edge detection (press = sync & ~sync_prev).
  - A held button produces exactly one press and must be released to press again.
- States: INIT, PLAY, HOLD, OVER.
- INIT: cell_reset=1 for exactly one cycle, then go to PLAY.
- PLAY: press_up ^ press_bottom selects the accepted press.
  - Simultaneous presses are a tie: both are discarded, with no pulse and no state change.
  - Accepted up press with lights_in[NUM_LIGHTS-1]=1: up wins the round. No pulse is issued. up_score increments (saturating), winner=1, go to HOLD.
  - Accepted bottom press with lights_in[0]=1: bottom wins the round. Same handling, with bottom_score and winner=2.
  - Any other accepted press registers a pulse on the matching output for exactly one cycle.
  - Latency: a raw rising edge first sampled at edge n gives a pulse high during cycle n+SYNC_STAGES+1.
  - Back-to-back presses on alternate cycles give alternate-cycle pulses.
  - lights_in is only inspected at the end bits. A multi-hot or all-zero vector is not corrected.
- HOLD: counter runs 0..HOLD_CYCLES-1 and winner is held.
  - On terminal count, if the winner's score equals WIN_SCORE: go to OVER, set match_over=1, keep winner.
  - Otherwise: winner=0, go to INIT.
- OVER: sticky until Reset. All presses are ignored, no pulses, cell_reset=0, scores frozen.
- Presses arriving in INIT, HOLD or OVER are dropped. The edge history still updates, so a button held across INIT does not fire in PLAY.
- Reset mid-round or mid-HOLD: abandon immediately and apply the reset values. Scores clear.
- Score saturates at 2^SCORE_W-1; it cannot exceed WIN_SCORE in a legal configuration.

Decomposition:
- Shared package light_pkg holds:
  - the state enum (INIT, PLAY, HOLD, OVER);
  - winner encoding constants WIN_NONE=0, WIN_UP=1, WIN_BOTTOM=2;
  - a function computing the HOLD counter width, $clog2(HOLD_CYCLES+1).
- One sub-module, btn_sync_edge (parameter SYNC_STAGES; ports Clock, Reset, raw, press), instantiated once per button.

Test Plan:
- Reset held 3 cycles, then released -> cell_reset=1 during Reset and for one cycle after; scores 0; state reaches PLAY; no pulses.
- btn_up rising edge, held 10 cycles, lights_in=9'b000010000 -> exactly one up_pulse, 3 cycles after the first sampling edge; no bottom_pulse.
- btn_up and btn_bottom rising on the same edge -> no pulse on either output and scores unchanged; a following solo bottom press yields one bottom_pulse.
- lights_in=9'b100000000, up press -> no up_pulse; up_score 0->1; winner=1 for 4 cycles; then cell_reset pulses once and PLAY resumes with winner=0.
- Bottom wins three rounds (lights_in[0]=1 at each press) -> bottom_score=3, match_over=1, winner=2 held; further presses give no pulses and no score change.
- Reset asserted during HOLD at count 2 -> next cycle all outputs are at their reset values, scores=0, and the INIT sequence restarts.
